uart_tx_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer that shares one UART Tx PISO core between NUM_REQ requesters.

---
 rtl/uart_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin sequencer sharing one UART Tx PISO core between NUM_REQ
//   requesters. A granted requester's byte and frame config are registered
//   onto the tx_* outputs. tx_send is then held until the core reports
//   completion. An idle gap of GAP_TICKS baud ticks follows each frame, and
//   done pulses for the requester that owned the frame.
//
//   Optional feature (macro UART_TX_ARB_TIMEOUT_EN):
//     A baud-tick watchdog runs in START/WAIT_DONE. When it reaches
//     TIMEOUT_TICKS the frame is aborted: tx_send drops, err pulses, and no
//     done pulse is issued. Without the macro err is constant 0.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_ni           asynchronous active-low reset
//   baud_tick_i      1-clock pulse per baud period
//   req_i            level request per requester
//   req_data_i       byte per requester, slice i = [8i+7:8i]
//   req_cfg_i        per requester {parity_type[1:0], stop_bits, data_length}
//   grant_o          one-hot pulse: inputs latched, requester may change them
//   done_o           one-hot pulse: that requester's frame finished
//   busy_o           high whenever the sequencer is not idle
//   owner_o          index of current/last granted requester
//   tx_data_o, tx_parity_type_o, tx_stop_bits_o, tx_data_length_o
//                    frame contents/config to the Tx core
//   tx_send_o        send level to the Tx core
//   tx_active_i      Tx core transmitting
//   tx_done_i        Tx core idle/done (high while idle)
//   err_o            timeout abort pulse
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 baud_tick_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [4*NUM_REQ-1:0] req_cfg_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic                 busy_o,
  output logic [2:0]           owner_o,
  output logic [7:0]           tx_data_o,
  output logic [1:0]           tx_parity_type_o,
  output logic                 tx_stop_bits_o,
  output logic                 tx_data_length_o,
  output logic                 tx_send_o,
  input  logic                 tx_active_i,
  input  logic                 tx_done_i,
  output logic                 err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1);
  localparam logic [2:0]         PTR_INIT = 3'(NUM_REQ - 1);
  localparam logic [3:0]         GAP_LAST = 4'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);

  state_e               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d, owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic                 busy_q, busy_d, send_q, send_d, err_q, err_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [3:0]           tx_cfg_q, tx_cfg_d;
  logic [3:0]           gap_q;
  logic                 pick_found_s;
  logic [2:0]           pick_idx_s;
  logic                 fin_s, gap_end_s, timeout_s, in_tx_s;
  logic [8*NUM_REQ-1:0] data_sh_s;
  logic [4*NUM_REQ-1:0] cfg_sh_s;

  assign fin_s     = tx_done_i & ~tx_active_i;
  assign in_tx_s   = (state_q == S_START) || (state_q == S_WAIT);
  assign data_sh_s = req_data_i >> {owner_q, 3'b000};
  assign cfg_sh_s  = req_cfg_i >> {owner_q, 2'b00};
  // GAP_TICKS=0 leaves GAP on the very next clock regardless of baud ticks.
  assign gap_end_s = (GAP_TICKS == 0) ? 1'b1 : (baud_tick_i && (gap_q == GAP_LAST));

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int           TW      = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);
  logic [TW-1:0] to_q;

  assign timeout_s = baud_tick_i && (to_q == TO_LAST);

  // Watchdog: cleared on LOAD, counts baud ticks while a frame is in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_q <= '0;
    end else if (state_q == S_LOAD) begin
      to_q <= '0;
    end else if (in_tx_s && baud_tick_i && !timeout_s) begin
      to_q <= to_q + TW'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Round-robin search: first set request after the pointer, with wrap.
  always_comb begin : arb_search
    logic [2:0] cand;
    logic       hit;
    pick_found_s = 1'b0;
    pick_idx_s   = ptr_q;
    cand         = 3'd0;
    hit          = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand         = 3'((int'(ptr_q) + k) % NUM_REQ);
      hit          = |(req_i & (REQ_ONE << cand));
      pick_idx_s   = (!pick_found_s && hit) ? cand : pick_idx_s;
      pick_found_s = pick_found_s | hit;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a clean finish wins over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = pick_found_s ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = S_START;
      S_START: begin
        if (timeout_s) begin
          state_d = S_GAP;
        end else if (tx_active_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_START;
        end
      end
      S_WAIT:  state_d = (fin_s || timeout_s) ? S_GAP : S_WAIT;
      S_GAP:   state_d = gap_end_s ? S_IDLE : S_GAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; everything below is registered.
  always_comb begin
    grant_d   = {NUM_REQ{1'b0}};
    done_d    = {NUM_REQ{1'b0}};
    err_d     = 1'b0;
    busy_d    = (state_d != S_IDLE);
    // send rises one clock after START is entered and drops on leaving WAIT.
    send_d    = in_tx_s && ((state_d == S_START) || (state_d == S_WAIT));
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    tx_cfg_d  = tx_cfg_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found_s) begin
          owner_d = pick_idx_s;
          ptr_d   = pick_idx_s;
        end else begin
          owner_d = owner_q;
          ptr_d   = ptr_q;
        end
      end
      S_LOAD: begin
        grant_d   = REQ_ONE << owner_q;
        tx_data_d = data_sh_s[7:0];
        tx_cfg_d  = cfg_sh_s[3:0];
      end
      S_START: err_d = timeout_s;
      S_WAIT: begin
        if (fin_s) begin
          done_d = REQ_ONE << owner_q;
        end else begin
          err_d = timeout_s;
        end
      end
      default: err_d = 1'b0;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q   <= {NUM_REQ{1'b0}};
      done_q    <= {NUM_REQ{1'b0}};
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      send_q    <= 1'b0;
      owner_q   <= 3'd0;
      ptr_q     <= PTR_INIT;
      tx_data_q <= 8'h00;
      tx_cfg_q  <= 4'b0001;
    end else begin
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      send_q    <= send_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      tx_cfg_q  <= tx_cfg_d;
    end
  end

  // Gap counter: only ticks sampled while already in GAP count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap_q <= 4'd0;
    end else if (state_q != S_GAP) begin
      gap_q <= 4'd0;
    end else if (baud_tick_i) begin
      gap_q <= gap_q + 4'd1;
    end
  end

  assign grant_o          = grant_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign busy_o           = busy_q;
  assign owner_o          = owner_q;
  assign tx_send_o        = send_q;
  assign tx_data_o        = tx_data_q;
  assign tx_parity_type_o = tx_cfg_q[3:2];
  assign tx_stop_bits_o   = tx_cfg_q[1];
  assign tx_data_length_o = tx_cfg_q[0];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int GAP = 2;

  logic          clk, rst_n, baud_tick;
  logic [NR-1:0] req;
  logic [31:0]   req_data;
  logic [15:0]   req_cfg;
  logic          tx_active, tx_done;
  logic [NR-1:0] grant, done;
  logic          busy, tx_stop, tx_len, tx_send, err;
  logic [2:0]    owner;
  logic [7:0]    tx_data;
  logic [1:0]    tx_par;

  // second instance with a zero-length gap
  logic [NR-1:0] req0, grant0, done0;
  logic          active0, txdone0, busy0, stop0, len0, send0, err0;
  logic [2:0]    owner0;
  logic [7:0]    data0;
  logic [1:0]    par0;

  int compares = 0;
  int mism     = 0;
  int tcount   = 0;
  int ptr_m    = NR - 1;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_TICKS(GAP), .TIMEOUT_TICKS(24)) dut (
    .clk_i(clk), .rst_ni(rst_n), .baud_tick_i(baud_tick), .req_i(req),
    .req_data_i(req_data), .req_cfg_i(req_cfg), .grant_o(grant), .done_o(done),
    .busy_o(busy), .owner_o(owner), .tx_data_o(tx_data), .tx_parity_type_o(tx_par),
    .tx_stop_bits_o(tx_stop), .tx_data_length_o(tx_len), .tx_send_o(tx_send),
    .tx_active_i(tx_active), .tx_done_i(tx_done), .err_o(err));

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_TICKS(0), .TIMEOUT_TICKS(24)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .baud_tick_i(baud_tick), .req_i(req0),
    .req_data_i(req_data), .req_cfg_i(req_cfg), .grant_o(grant0), .done_o(done0),
    .busy_o(busy0), .owner_o(owner0), .tx_data_o(data0), .tx_parity_type_o(par0),
    .tx_stop_bits_o(stop0), .tx_data_length_o(len0), .tx_send_o(send0),
    .tx_active_i(active0), .tx_done_i(txdone0), .err_o(err0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to the next falling edge and draw a fresh random baud tick
  task automatic tick();
    @(negedge clk);
    baud_tick = ($urandom_range(0, 2) == 0);
    tcount += int'(baud_tick);
  endtask

  // reference rotation: first set bit after the pointer, wrapping
  function automatic int rr_pick(input logic [NR-1:0] m, input int p);
    for (int k = 1; k <= NR; k++) begin
      if (m[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  // Entered on a falling edge with the DUT idle and req already applied.
  // Ends on the falling edge where the DUT is first seen idle again.
  task automatic serve_frame(input int exp_own, input logic [NR-1:0] drop_m,
                             input logic [NR-1:0] pulse_m, input int act_ticks);
    logic [31:0] dsh;
    logic [15:0] csh;
    logic [7:0]  ed;
    logic [3:0]  ec;
    int st, g0, guard, sent_low;
    dsh = req_data >> (8 * exp_own);
    csh = req_cfg >> (4 * exp_own);
    ed  = dsh[7:0];
    ec  = csh[3:0];
    tick();
    chk("busy_load", busy, 1);
    chk("owner", owner, exp_own);
    chk("grant_early", grant, 0);
    tick();
    chk("grant", grant, 32'(1) << exp_own);
    chk("tx_data", tx_data, ed);
    chk("tx_parity", tx_par, ec[3:2]);
    chk("tx_stop", tx_stop, ec[1]);
    chk("tx_len", tx_len, ec[0]);
    chk("send_early", tx_send, 0);
    req = req & ~drop_m;
    tick();
    chk("send", tx_send, 1);
    chk("grant_pulse", grant, 0);
    repeat ($urandom_range(0, 2)) tick();
    tx_active = 1'b1;
    tx_done   = 1'b0;
    st        = tcount;
    sent_low  = 0;
    req = req | pulse_m;
    tick();
    req = req & ~pulse_m;
    guard = 0;
    while ((tcount - st) < act_ticks && guard < 1000) begin
      if (tx_send !== 1'b1) sent_low++;
      tick();
      guard++;
    end
    chk("send_hold", sent_low, 0);
    tx_active = 1'b0;
    tx_done   = 1'b1;
    tick();
    chk("done", done, 32'(1) << exp_own);
    chk("send_drop", tx_send, 0);
    chk("busy_gap", busy, 1);
    chk("err_none", err, 0);
    g0 = tcount - int'(baud_tick);
    tick();
    chk("done_pulse", done, 0);
    guard = 0;
    while (busy !== 1'b0 && guard < 400) begin
      tick();
      guard++;
    end
    chk("gap_idle", busy, 0);
    chk("gap_ticks", (tcount - int'(baud_tick)) - g0, GAP);
  endtask

  initial begin
    int exp_o, n, busy_seen;
    logic [NR-1:0] m;
    rst_n = 1'b0; baud_tick = 1'b0; req = '0; req_data = '0; req_cfg = '0;
    tx_active = 1'b0; tx_done = 1'b1;
    req0 = '0; active0 = 1'b0; txdone0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_outs", {grant, done, err, tx_send}, 0);
    chk("rst_cfg", {tx_data, tx_par, tx_stop, tx_len}, 12'h001);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // single request from requester 1
    req_data = 32'h0000_A500;
    req_cfg  = 16'h0060;
    req      = 4'b0010;
    exp_o = rr_pick(req, ptr_m); ptr_m = exp_o;
    chk("single_pick", exp_o, 1);
    serve_frame(exp_o, 4'b0010, 4'b0000, 10);

    // reset in the middle of a frame
    req = 4'b0010;
    repeat (3) tick();
    tx_active = 1'b1; tx_done = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_send", tx_send, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_data", tx_data, 8'h00);
    req = '0; tx_active = 1'b0; tx_done = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    ptr_m = NR - 1;
    busy_seen = 0;
    repeat (4) begin
      tick();
      if (done !== 4'b0000 || busy !== 1'b0) busy_seen++;
    end
    chk("midrst_quiet", busy_seen, 0);

    // round robin with all requests held
    req_data = 32'h4433_2211;
    req_cfg  = 16'hB7C4;
    req      = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp_o = rr_pick(req, ptr_m); ptr_m = exp_o;
      chk("rr_order", exp_o, f % NR);
      serve_frame(exp_o, 4'b0000, 4'b0000, $urandom_range(2, 6));
    end

    // requester 2 busy while req0 pulses one clock; then req3 dropped after grant
    req = 4'b0100;
    exp_o = rr_pick(req, ptr_m); ptr_m = exp_o;
    serve_frame(exp_o, 4'b0100, 4'b0001, 6);
    busy_seen = 0;
    repeat (6) begin
      tick();
      if (busy !== 1'b0) busy_seen++;
    end
    chk("early_drop", busy_seen, 0);
    req = 4'b1000;
    exp_o = rr_pick(req, ptr_m); ptr_m = exp_o;
    serve_frame(exp_o, 4'b1000, 4'b0000, 5);

    // randomized masks, data and config
    for (int f = 0; f < 8; f++) begin
      m        = 4'($urandom_range(1, 15));
      req_data = $urandom;
      req_cfg  = 16'($urandom);
      req      = m;
      exp_o = rr_pick(m, ptr_m); ptr_m = exp_o;
      serve_frame(exp_o, ($urandom_range(0, 1) == 1) ? m : 4'b0000, 4'b0000,
                  $urandom_range(1, 12));
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // core never starts: watchdog abort after 24 ticks, then next requester
    req = 4'b0001;
    exp_o = rr_pick(req, ptr_m); ptr_m = exp_o;
    tick(); tick();
    chk("to_grant", grant, 32'(1) << exp_o);
    n = tcount - int'(baud_tick);
    busy_seen = 0;
    while (err !== 1'b1 && busy_seen < 2000) begin
      tick();
      busy_seen++;
    end
    chk("to_err", err, 1);
    chk("to_ticks", (tcount - int'(baud_tick)) - n, 24);
    chk("to_send", tx_send, 0);
    chk("to_nodone", done, 0);
    req = 4'b0010;
    busy_seen = 0;
    while (busy !== 1'b0 && busy_seen < 400) begin
      tick();
      busy_seen++;
    end
    exp_o = rr_pick(req, ptr_m); ptr_m = exp_o;
    serve_frame(exp_o, 4'b0010, 4'b0000, 4);
`else
    chk("err_tied", err, 0);
`endif

    // zero gap: back-to-back request re-sends 4 clocks after done
    req0 = 4'b0001;
    tick(); tick();
    chk("g0_grant", grant0, 4'b0001);
    tick();
    chk("g0_send", send0, 1);
    active0 = 1'b1; txdone0 = 1'b0;
    repeat (3) tick();
    active0 = 1'b0; txdone0 = 1'b1;
    tick();
    chk("g0_done", done0, 4'b0001);
    chk("g0_owner", owner0, 0);
    n = 0;
    while (send0 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("g0_resend", n, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end
endmodule
